arm_exec_pipe: RTL and testbench
================================

ARM_EXEC_PIPE -- requirements
Module: arm_exec_pipe

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter STAGES, default 2, range 1..4, register stages from accept to writeback.
REQ-003 Parameter RA_W, default 4, register address width.
REQ-004 clk1  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  micro-op present.
REQ-007 in_ready  out  1  micro-op accepted on a cycle with in_valid&&in_ready.
REQ-008 in_mode  in  4  0 data-proc, 1 MUL, 2 MLA, 3 UMULL, 4 SMULL, 15 skip-ALU (pass op_b).
REQ-009 in_opcode  in  4  ARM data-processing opcode (AND..MVN); ignored when in_mode!=0.
REQ-010 in_s  in  1  update flags.
REQ-011 in_op_a, in_op_b, in_op_c  in  DATA_W each  Rn/Rm, shifted operand2/Rs, MLA accumulate.
REQ-012 in_shc  in  1  barrel-shifter carry-out for logical ops.
REQ-013 in_rd, in_rd2  in  RA_W each  destination; in_rd2 = RdLo for long multiply.
REQ-014 flush  in  1  kill all in-flight micro-ops.
REQ-015 wb_valid  out  1  register write this cycle.
REQ-016 wb_addr  out  RA_W; wb_data  out  DATA_W  write address/data.
REQ-017 flags  out  4  architectural {N,Z,C,V}.
REQ-018 flags_we  out  1  flags updated at this edge.

Function
REQ-019 Micro-op SHALL travel STAGES registers; compute is combinational in the final stage; wb_valid asserts exactly STAGES cycles after acceptance.
REQ-020 Final stage SHALL use the current flags register for ADC/SBC/RSC carry, so back-to-back flag-setting ops see correct in-order flags without forwarding.
REQ-021 Arithmetic ops: C = carry-out (SUB-type: NOT borrow), V = signed overflow; logical ops: C = in_shc, V unchanged; N = result[DATA_W-1], Z = result==0.
REQ-022 TST/TEQ/CMP/CMN SHALL update flags (regardless of in_s) and SHALL NOT assert wb_valid.
REQ-023 MUL writes low DATA_W bits of a*b; MLA writes low bits of a*b+c; with in_s, N/Z updated, C/V unchanged.
REQ-024 UMULL/SMULL SHALL take two writeback cycles: cycle 1 high word to in_rd, cycle 2 low word to in_rd2; flags (N=bit 2*DATA_W-1, Z=full product zero) update on cycle 1.
REQ-025 During the second long-multiply cycle the pipe SHALL hold all stages and deassert in_ready for that cycle only.
REQ-026 Skip-ALU SHALL write in_op_b unchanged; with in_s, N/Z update only.
REQ-027 in_ready SHALL otherwise be 1; pipe accepts one micro-op per cycle.
REQ-028 flush SHALL clear every stage valid bit at the next edge, including a same-cycle accepted op and a pending long-multiply low write; flags SHALL NOT update that edge; flush wins over all events.
REQ-029 wb_data/wb_addr SHALL be 0 whenever wb_valid is 0.
REQ-030 flags_we SHALL pulse one cycle per flag update; flags output reflects value after the edge.

Reset
REQ-031 reset SHALL clear all stage valids, long-multiply state, flags to 0000; in_ready=1, wb_valid=0, flags_we=0 during and after reset.
REQ-032 reset mid long-multiply SHALL abandon the low-word write.

Configuration
REQ-033 Macro ARM_EXEC_LONG_MULT_EN: defined -> REQ-024/025 behaviour; undefined -> modes 3/4 behave as MUL (single write of low word to in_rd, in_ready never deasserts), no 2*DATA_W multiplier built.

Verification
REQ-034 STAGES=2: ADDS a=5,b=0x0F -> 2 cycles later wb rd=0, data=0x14, flags=0000, flags_we=1.
REQ-035 SUBS a=3,b=3 then ADC a=1,b=1 back-to-back -> first flags Z=1,C=1 (0110); second writes 3.
REQ-036 UMULL a=0xFFFFFFFF,b=2, rd=1, rd2=0 -> wb 1<=0x00000001 then 0<=0xFFFFFFFE; in_ready low one cycle; following op delayed one cycle. Without macro: single write 0xFFFFFFFE.
REQ-037 SMULL a=0xFFFFFFFF(-1),b=2, S=1 -> hi 0xFFFFFFFF, lo 0xFFFFFFFE, N=1.
REQ-038 CMP a=3,b=5 -> no wb_valid, flags N=1,Z=0,C=0,V=0.
REQ-039 flush asserted while ADD and UMULL in flight (and during UMULL low cycle) -> no further wb_valid, flags unchanged; next op after flush completes normally.

Source files
------------

// File: rtl/arm_exec_pipe.sv
// ARM execute pipeline: STAGES-deep micro-op pipe, ALU/multiplier in the final stage, in-order flags.
// Define ARM_EXEC_LONG_MULT_EN to build the 2*DATA_W UMULL/SMULL path with its two-cycle writeback.
module arm_exec_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int RA_W   = 4
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mode,
  input  logic [3:0]        in_opcode,
  input  logic              in_s,
  input  logic [DATA_W-1:0] in_op_a,
  input  logic [DATA_W-1:0] in_op_b,
  input  logic [DATA_W-1:0] in_op_c,
  input  logic              in_shc,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [RA_W-1:0]   in_rd2,
  input  logic              flush,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags,
  output logic              flags_we
);

  typedef struct packed {
    logic [3:0]        mode;
    logic [3:0]        opcode;
    logic              s;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic              shc;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rd2;
  } uop_t;

  uop_t              stage_reg [STAGES];
  logic [STAGES-1:0] valid_reg;
  logic              lo_pending_reg;
  logic [RA_W-1:0]   lo_addr_reg;
  logic [DATA_W-1:0] lo_data_reg;
  logic [3:0]        flags_reg;

  uop_t              in_uop;
  uop_t              fin;
  logic              kill, advance, accept, fin_live;
  logic [DATA_W-1:0] res, x, y, mul_lo, lo_word;
  logic [DATA_W:0]   sum;
  logic              cin, arith, do_wb, upd, long_op;
  logic [3:0]        nf;

  assign in_uop   = {in_mode, in_opcode, in_s, in_op_a, in_op_b, in_op_c, in_shc, in_rd, in_rd2};
  assign kill     = reset || flush;
  // The low-word cycle of a long multiply freezes every stage.
  assign advance  = !lo_pending_reg;
  assign accept   = in_valid && !lo_pending_reg;
  assign in_ready = reset || !lo_pending_reg;
  assign fin      = stage_reg[STAGES-1];
  assign fin_live = valid_reg[STAGES-1] && !lo_pending_reg;

  always_ff @(posedge clk1) begin
    if (advance) begin
      stage_reg[0] <= in_uop;
      for (int k = 1; k < STAGES; k++) stage_reg[k] <= stage_reg[k-1];
    end
  end

  always_ff @(posedge clk1) begin
    if (kill) begin
      valid_reg <= '0;
    end else if (advance) begin
      valid_reg[0] <= accept;
      for (int k = 1; k < STAGES; k++) valid_reg[k] <= valid_reg[k-1];
    end
  end

`ifdef ARM_EXEC_LONG_MULT_EN
  logic [2*DATA_W-1:0] prod_u, prod_s, prod_l;
  assign prod_u = {{DATA_W{1'b0}}, fin.a} * {{DATA_W{1'b0}}, fin.b};
  // Sign-extended operands give the signed product in the low 2*DATA_W bits.
  assign prod_s = {{DATA_W{fin.a[DATA_W-1]}}, fin.a} * {{DATA_W{fin.b[DATA_W-1]}}, fin.b};
  assign prod_l = (fin.mode == 4'd4) ? prod_s : prod_u;
  assign mul_lo = prod_u[DATA_W-1:0];
`else
  assign mul_lo = fin.a * fin.b;
`endif

  always_comb begin
    res     = '0;
    do_wb   = 1'b1;
    upd     = 1'b0;
    nf      = flags_reg;
    x       = fin.a;
    y       = fin.b;
    cin     = 1'b0;
    arith   = 1'b0;
    sum     = '0;
    long_op = 1'b0;
    lo_word = '0;
    case (fin.mode)
      4'd0: begin
        upd = fin.s;
        case (fin.opcode)
          4'h0, 4'h8: res = fin.a & fin.b;
          4'h1, 4'h9: res = fin.a ^ fin.b;
          4'h2, 4'hA: begin arith = 1'b1; y = ~fin.b; cin = 1'b1; end
          4'h3:       begin arith = 1'b1; x = ~fin.a; cin = 1'b1; end
          4'h4, 4'hB: arith = 1'b1;
          4'h5:       begin arith = 1'b1; cin = flags_reg[1]; end
          4'h6:       begin arith = 1'b1; y = ~fin.b; cin = flags_reg[1]; end
          4'h7:       begin arith = 1'b1; x = ~fin.a; cin = flags_reg[1]; end
          4'hC:       res = fin.a | fin.b;
          4'hD:       res = fin.b;
          4'hE:       res = fin.a & ~fin.b;
          default:    res = ~fin.b;
        endcase
        // TST/TEQ/CMP/CMN: flags only, no register write.
        if (fin.opcode[3:2] == 2'b10) begin
          upd   = 1'b1;
          do_wb = 1'b0;
        end
        sum = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, cin};
        if (arith) res = sum[DATA_W-1:0];
        nf = {res[DATA_W-1], res == '0,
              arith ? sum[DATA_W] : fin.shc,
              arith ? ((x[DATA_W-1] == y[DATA_W-1]) && (res[DATA_W-1] != x[DATA_W-1])) : flags_reg[0]};
      end
      4'd1, 4'd2: begin
        upd = fin.s;
        res = (fin.mode == 4'd2) ? mul_lo + fin.c : mul_lo;
        nf  = {res[DATA_W-1], res == '0, flags_reg[1:0]};
      end
      4'd3, 4'd4: begin
        upd = fin.s;
`ifdef ARM_EXEC_LONG_MULT_EN
        long_op = 1'b1;
        res     = prod_l[2*DATA_W-1:DATA_W];
        lo_word = prod_l[DATA_W-1:0];
        nf      = {prod_l[2*DATA_W-1], prod_l == '0, flags_reg[1:0]};
`else
        res = mul_lo;
        nf  = {res[DATA_W-1], res == '0, flags_reg[1:0]};
`endif
      end
      default: begin
        upd = fin.s;
        res = fin.b;
        nf  = {res[DATA_W-1], res == '0, flags_reg[1:0]};
      end
    endcase
  end

  assign wb_valid = !kill && (lo_pending_reg || (fin_live && do_wb));
  assign wb_addr  = !wb_valid ? '0 : (lo_pending_reg ? lo_addr_reg : fin.rd);
  assign wb_data  = !wb_valid ? '0 : (lo_pending_reg ? lo_data_reg : res);
  assign flags_we = !kill && fin_live && upd;
  assign flags    = flags_reg;

  always_ff @(posedge clk1) begin
    if (reset)         flags_reg <= 4'b0000;
    else if (flags_we) flags_reg <= nf;
  end

  always_ff @(posedge clk1) begin
    if (kill || lo_pending_reg) begin
      lo_pending_reg <= 1'b0;
    end else if (fin_live && long_op) begin
      lo_pending_reg <= 1'b1;
      lo_addr_reg    <= fin.rd2;
      lo_data_reg    <= lo_word;
    end
  end

endmodule

// File: tb/tb_arm_exec_pipe.sv
// Scoreboard bench for arm_exec_pipe (STAGES=2); expectations follow ARM_EXEC_LONG_MULT_EN when defined.
module tb_arm_exec_pipe;
`ifdef ARM_EXEC_LONG_MULT_EN
  localparam int LM = 1;
`else
  localparam int LM = 0;
`endif

  logic        clk1 = 1'b0;
  logic        reset = 1'b1, in_valid = 1'b0, in_s = 1'b0, in_shc = 1'b0, flush = 1'b0;
  logic        in_ready, wb_valid, flags_we;
  logic [3:0]  in_mode = '0, in_opcode = '0, in_rd = '0, in_rd2 = '0, wb_addr, flags;
  logic [31:0] in_op_a = '0, in_op_b = '0, in_op_c = '0, wb_data;

  typedef struct packed { logic [3:0] addr; logic [31:0] data; } wb_t;
  wb_t        exp_wb[$];
  logic [3:0] exp_fl[$];
  wb_t        e_wb;
  logic [3:0] fexp;
  bit         fchk = 0, mon_en = 0;
  int         n_checks = 0, n_fail = 0, cyc = 0, rdy_low = 0, acc_cyc = 0, t0 = 0;
  int         wb_cycle [16];

  arm_exec_pipe #(.DATA_W(32), .STAGES(2), .RA_W(4)) dut (
    .clk1(clk1), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_opcode(in_opcode), .in_s(in_s),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_op_c(in_op_c), .in_shc(in_shc),
    .in_rd(in_rd), .in_rd2(in_rd2), .flush(flush),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flags(flags), .flags_we(flags_we)
  );

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every write / flag update (flush cycles are not scored).
  always @(negedge clk1) begin
    if (mon_en) begin
      if (!in_ready) rdy_low++;
      if (fchk) begin
        n_checks++;
        if (flags !== fexp) begin
          n_fail++;
          $display("FAIL flags_after_update: got %b expected %b", flags, fexp);
        end
        fchk = 0;
      end
      if (!flush) begin
        n_checks++;
        if (wb_valid) begin
          wb_cycle[wb_addr] = cyc;
          $display("cycle %0d: wb r%0d <= %h", cyc, wb_addr, wb_data);
          if (exp_wb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_wb: got r%0d=%h expected no write", wb_addr, wb_data);
          end else begin
            e_wb = exp_wb.pop_front();
            if ({wb_addr, wb_data} !== e_wb) begin
              n_fail++;
              $display("FAIL wb_data: got r%0d=%h expected r%0d=%h", wb_addr, wb_data, e_wb.addr, e_wb.data);
            end
          end
        end else if (wb_addr !== 4'd0 || wb_data !== 32'd0) begin
          n_fail++;
          $display("FAIL wb_idle_zero: got r%0d=%h expected 0/0", wb_addr, wb_data);
        end
        if (flags_we) begin
          n_checks++;
          if (exp_fl.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_flags_we: got flags_we=1 expected 0");
          end else begin
            fexp = exp_fl.pop_front();
            fchk = 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [3:0] mode, input logic [3:0] opc, input logic s,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic shc, input logic [3:0] rd, input logic [3:0] rd2);
    in_valid = 1'b1; in_mode = mode; in_opcode = opc; in_s = s;
    in_op_a = a; in_op_b = b; in_op_c = c; in_shc = shc; in_rd = rd; in_rd2 = rd2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk1);
      if (in_ready) begin
        acc_cyc = cyc;
        @(posedge clk1); #1;
        return;
      end
      @(posedge clk1); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL accept_timeout: got in_ready=0 for 8 cycles expected acceptance");
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk1); #1; end
  endtask

  task automatic clr_wbc();
    foreach (wb_cycle[i]) wb_cycle[i] = -1;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_flags(input string name, input logic [3:0] exp);
    n_checks++;
    if (flags !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, flags, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_mode = 4'd0; in_opcode = 4'h4; in_s = 1'b1;
    repeat (3) begin
      @(negedge clk1);
      n_checks++;
      if (in_ready !== 1'b1 || wb_valid !== 1'b0 || flags_we !== 1'b0 || flags !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_state: got rdy=%b wbv=%b fwe=%b flags=%b expected 1 0 0 0000",
                 in_ready, wb_valid, flags_we, flags);
      end
    end
    @(posedge clk1); #1;
    reset = 1'b0; in_valid = 1'b0; in_s = 1'b0;
    mon_en = 1;
    idle(3);
  endtask

  task automatic test_adds();
    clr_wbc();
    exp_wb.push_back({4'd0, 32'h14}); exp_fl.push_back(4'b0000);
    send(4'd0, 4'h4, 1'b1, 32'd5, 32'h0F, 32'd0, 1'b0, 4'd0, 4'd0);
    t0 = acc_cyc;
    idle(4);
    check_int("adds_latency", wb_cycle[0] - t0, 2);
    check_flags("adds_flags", 4'b0000);
  endtask

  task automatic test_back_to_back();
    clr_wbc();
    exp_wb.push_back({4'd2, 32'd0}); exp_fl.push_back(4'b0110);
    send(4'd0, 4'h2, 1'b1, 32'd3, 32'd3, 32'd0, 1'b0, 4'd2, 4'd0);
    exp_wb.push_back({4'd3, 32'd3});
    send(4'd0, 4'h5, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 4'd3, 4'd0);
    idle(4);
    check_int("b2b_spacing", wb_cycle[3] - wb_cycle[2], 1);
    check_flags("subs_flags", 4'b0110);
  endtask

  task automatic test_cmp();
    clr_wbc();
    exp_fl.push_back(4'b1000);
    send(4'd0, 4'hA, 1'b0, 32'd3, 32'd5, 32'd0, 1'b0, 4'd4, 4'd0);
    idle(4);
    check_int("cmp_no_wb", wb_cycle[4], -1);
    check_flags("cmp_flags", 4'b1000);
  endtask

  task automatic test_logic();
    exp_wb.push_back({4'd5, 32'd0}); exp_fl.push_back(4'b0110);
    send(4'd0, 4'h0, 1'b1, 32'hF0, 32'h0F, 32'd0, 1'b1, 4'd5, 4'd0);
    exp_wb.push_back({4'd6, 32'hFFFF_FFFF}); exp_fl.push_back(4'b1000);
    send(4'd0, 4'hF, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 4'd6, 4'd0);
    exp_wb.push_back({4'd7, 32'hF0});
    send(4'd0, 4'h1, 1'b0, 32'hFF, 32'h0F, 32'd0, 1'b0, 4'd7, 4'd0);
    exp_wb.push_back({4'd8, 32'h8000_0000}); exp_fl.push_back(4'b1001);
    send(4'd0, 4'h4, 1'b1, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 4'd8, 4'd0);
    idle(4);
    check_flags("overflow_flags", 4'b1001);
  endtask

  task automatic test_mul();
    exp_wb.push_back({4'd9, 32'd42});
    send(4'd1, 4'h0, 1'b0, 32'd7, 32'd6, 32'd0, 1'b0, 4'd9, 4'd0);
    exp_wb.push_back({4'd10, 32'd0}); exp_fl.push_back(4'b0101);
    send(4'd2, 4'h0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 4'd10, 4'd0);
    exp_wb.push_back({4'd11, 32'h8000_0000}); exp_fl.push_back(4'b1001);
    send(4'd15, 4'h0, 1'b1, 32'd0, 32'h8000_0000, 32'd0, 1'b1, 4'd11, 4'd0);
    idle(4);
    check_flags("skip_alu_flags", 4'b1001);
  endtask

  task automatic test_long();
    clr_wbc(); rdy_low = 0;
    if (LM == 1) begin
      exp_wb.push_back({4'd1, 32'd1}); exp_wb.push_back({4'd0, 32'hFFFF_FFFE});
    end else begin
      exp_wb.push_back({4'd1, 32'hFFFF_FFFE});
    end
    send(4'd3, 4'h0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 4'd1, 4'd0);
    t0 = acc_cyc;
    exp_wb.push_back({4'd5, 32'd2});
    send(4'd0, 4'h4, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 4'd5, 4'd0);
    exp_wb.push_back({4'd6, 32'd9});
    send(4'd0, 4'hD, 1'b0, 32'd0, 32'd9, 32'd0, 1'b0, 4'd6, 4'd0);
    idle(6);
    check_int("umull_ready_low", rdy_low, LM);
    check_int("umull_hi_latency", wb_cycle[1] - t0, 2);
    check_int("umull_next_delay", wb_cycle[5] - t0, 3 + LM);
    check_int("umull_third_delay", wb_cycle[6] - t0, 4 + LM);
    check_flags("umull_flags_kept", 4'b1001);
  endtask

  task automatic test_smull();
    exp_wb.push_back({4'd2, 32'd1}); exp_fl.push_back(4'b0001);
    send(4'd0, 4'hD, 1'b1, 32'd0, 32'd1, 32'd0, 1'b0, 4'd2, 4'd0);
    if (LM == 1) begin
      exp_wb.push_back({4'd7, 32'hFFFF_FFFF}); exp_wb.push_back({4'd8, 32'hFFFF_FFFE});
    end else begin
      exp_wb.push_back({4'd7, 32'hFFFF_FFFE});
    end
    exp_fl.push_back(4'b1001);
    send(4'd4, 4'h0, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 4'd7, 4'd8);
    idle(6);
    check_flags("smull_flags", 4'b1001);
  endtask

  task automatic test_flush();
    clr_wbc();
    send(4'd0, 4'h4, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 4'd9, 4'd0);
    in_mode = 4'd3; in_opcode = 4'h0; in_s = 1'b1; in_op_a = 32'hFFFF_FFFF; in_op_b = 32'd2;
    in_rd = 4'd10; in_rd2 = 4'd11; flush = 1'b1;
    @(posedge clk1); #1;
    flush = 1'b0; in_valid = 1'b0;
    idle(5);
    check_int("flush_kills_add", wb_cycle[9], -1);
    check_int("flush_kills_umull", wb_cycle[10], -1);
    check_flags("flush_flags_kept", 4'b1001);

    if (LM == 1) exp_wb.push_back({4'd12, 32'd1});
    else         exp_wb.push_back({4'd12, 32'hFFFF_FFFE});
    send(4'd3, 4'h0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 4'd12, 4'd13);
    in_valid = 1'b0;
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    flush = 1'b1;
    @(posedge clk1); #1;
    flush = 1'b0;
    idle(3);
    check_int("flush_low_word", wb_cycle[13], -1);
    exp_wb.push_back({4'd14, 32'd4});
    send(4'd0, 4'h4, 1'b0, 32'd2, 32'd2, 32'd0, 1'b0, 4'd14, 4'd0);
    t0 = acc_cyc;
    idle(4);
    check_int("after_flush_latency", wb_cycle[14] - t0, 2);
    check_flags("after_flush_flags", 4'b1001);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    clr_wbc();
    test_reset();
    test_adds();
    test_back_to_back();
    test_cmp();
    test_logic();
    test_mul();
    test_long();
    test_smull();
    test_flush();
    idle(3);
    check_int("wb_queue_drained", exp_wb.size(), 0);
    check_int("flag_queue_drained", exp_fl.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
